// File: rtl/wb_check_pipe.sv
// rtl/wb_check_pipe.sv - fixed-latency writeback scoreboard for the pipelined ARMS core
// Optional macro WBCHK_ONEHOT_EN adds a one-hot legality check on observed dselect.
module wb_check_pipe #(
    parameter int DATA_W     = 64,
    parameter int ADDR_W     = 64,
    parameter int NREGS      = 32,
    parameter int PIPE_DEPTH = 4,
    parameter int ERR_W      = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              exp_valid,
    input  logic [ADDR_W-1:0] exp_pc,
    input  logic [NREGS-1:0]  exp_sel,
    input  logic              exp_sel_dc,
    input  logic [DATA_W-1:0] exp_data,
    input  logic              exp_data_dc,
    input  logic [ADDR_W-1:0] iaddrbus,
    input  logic [NREGS-1:0]  dselect,
    input  logic [DATA_W-1:0] dbus,
    output logic              err_pc,
    output logic              err_sel,
    output logic              err_data,
    output logic [15:0]       err_idx,
    output logic [ERR_W-1:0]  err_count,
    output logic [ERR_W-1:0]  chk_count,
    output logic              pass
);

    typedef struct packed {
        logic              valid;
        logic [NREGS-1:0]  sel;
        logic              sel_dc;
        logic [DATA_W-1:0] data;
        logic              data_dc;
        logic [15:0]       tag;
    } stage_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_FAIL
    } state_t;

    stage_t      pipe [PIPE_DEPTH];
    stage_t      ret;
    logic [15:0] issue_cnt;
    logic        pc_bad;
    logic        sel_bad;
    logic        data_bad;
    logic        any_bad;
    logic        sel_ok;
    state_t      state;
    state_t      state_next;

    assign ret = pipe[PIPE_DEPTH-1];

`ifdef WBCHK_ONEHOT_EN
    // Zero and multi-bit selects are both illegal writebacks, whatever the record says.
    logic sel_onehot;
    assign sel_onehot = (dselect != '0) && ((dselect & (dselect - NREGS'(1))) == '0);
    assign sel_ok     = (dselect == ret.sel) && sel_onehot;
`else
    assign sel_ok     = (dselect == ret.sel);
`endif

    always_comb begin
        pc_bad   = exp_valid && (iaddrbus != exp_pc);
        sel_bad  = ret.valid && !ret.sel_dc && !sel_ok;
        data_bad = ret.valid && !ret.data_dc && (dbus != ret.data);
        any_bad  = pc_bad || sel_bad || data_bad;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < PIPE_DEPTH; i++) begin
                pipe[i] <= '0;
            end
            issue_cnt <= '0;
            err_pc    <= 1'b0;
            err_sel   <= 1'b0;
            err_data  <= 1'b0;
            err_idx   <= '0;
            err_count <= '0;
            chk_count <= '0;
        end else begin
            pipe[0] <= {exp_valid, exp_sel, exp_sel_dc, exp_data, exp_data_dc, issue_cnt};
            for (int i = 1; i < PIPE_DEPTH; i++) begin
                pipe[i] <= pipe[i-1];
            end
            if (exp_valid) begin
                issue_cnt <= issue_cnt + 16'd1;
            end
            err_pc   <= pc_bad;
            err_sel  <= sel_bad;
            err_data <= data_bad;
            if (sel_bad || data_bad) begin
                err_idx <= ret.tag;
            end
            // One count per erroring cycle, regardless of how many flags fire.
            if (any_bad && (err_count != '1)) begin
                err_count <= err_count + ERR_W'(1);
            end
            if (ret.valid && (chk_count != '1)) begin
                chk_count <= chk_count + ERR_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= ST_IDLE;
            pass  <= 1'b0;
        end else begin
            state <= state_next;
            pass  <= (state_next == ST_RUN);
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: begin
                if (any_bad) begin
                    state_next = ST_FAIL;
                end else if (ret.valid) begin
                    state_next = ST_RUN;
                end
            end
            ST_RUN: begin
                if (any_bad) begin
                    state_next = ST_FAIL;
                end
            end
            ST_FAIL: state_next = ST_FAIL;
            default: state_next = ST_IDLE;
        endcase
    end

endmodule

// File: tb/tb_wb_check_pipe.sv
// tb/tb_wb_check_pipe.sv - table-driven bench for wb_check_pipe (PIPE_DEPTH=4)
module tb_wb_check_pipe;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        exp_valid;
    logic [63:0] exp_pc;
    logic [31:0] exp_sel;
    logic        exp_sel_dc;
    logic [63:0] exp_data;
    logic        exp_data_dc;
    logic [63:0] iaddrbus;
    logic [31:0] dselect;
    logic [63:0] dbus;
    logic        err_pc;
    logic        err_sel;
    logic        err_data;
    logic [15:0] err_idx;
    logic [15:0] err_count;
    logic [15:0] chk_count;
    logic        pass;

    int n_cmp = 0;
    int n_bad = 0;

`ifdef WBCHK_ONEHOT_EN
    localparam bit OH = 1'b1;
`else
    localparam bit OH = 1'b0;
`endif

    wb_check_pipe #(
        .DATA_W(64), .ADDR_W(64), .NREGS(32), .PIPE_DEPTH(4), .ERR_W(16)
    ) dut (
        .clk(clk), .reset(rst_n),
        .exp_valid(exp_valid), .exp_pc(exp_pc), .exp_sel(exp_sel), .exp_sel_dc(exp_sel_dc),
        .exp_data(exp_data), .exp_data_dc(exp_data_dc),
        .iaddrbus(iaddrbus), .dselect(dselect), .dbus(dbus),
        .err_pc(err_pc), .err_sel(err_sel), .err_data(err_data), .err_idx(err_idx),
        .err_count(err_count), .chk_count(chk_count), .pass(pass)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic        ev;
        logic [63:0] pc;
        logic [31:0] sel;
        logic        sdc;
        logic [63:0] data;
        logic        ddc;
        logic [63:0] ia;
        logic [31:0] ds;
        logic [63:0] db;
        logic        x_pc;
        logic        x_sel;
        logic        x_data;
        logic [15:0] x_idx;
        logic [15:0] x_ecnt;
        logic [15:0] x_ccnt;
        logic        x_pass;
    } vec_t;

    vec_t tbl[$];

    function automatic logic [63:0] rec_pc(int i);
        return 64'(4 * i);
    endfunction

    function automatic logic [31:0] rec_sel(int i);
        return 32'd1 << ((20 + i) % 32);
    endfunction

    function automatic logic [63:0] rec_data(int i);
        return 64'hAAA + 64'(i) * 64'h111;
    endfunction

    function automatic vec_t idle_row();
        vec_t v;
        v.rst = 1'b1; v.ev = 1'b0; v.pc = '0; v.sel = '0; v.sdc = 1'b0;
        v.data = '0; v.ddc = 1'b0;
        v.ia = 64'hDEAD_BEEF_0BAD_F00D; v.ds = 32'hFFFF_0000; v.db = 64'h0123_4567_89AB_CDEF;
        v.x_pc = 1'b0; v.x_sel = 1'b0; v.x_data = 1'b0; v.x_idx = '0;
        v.x_ecnt = '0; v.x_ccnt = '0; v.x_pass = 1'b0;
        return v;
    endfunction

    function automatic vec_t issue(vec_t vin, int i);
        vec_t v = vin;
        v.ev = 1'b1; v.pc = rec_pc(i); v.sel = rec_sel(i); v.data = rec_data(i); v.ia = rec_pc(i);
        return v;
    endfunction

    function automatic vec_t wb(vec_t vin, int i);
        vec_t v = vin;
        v.ds = rec_sel(i); v.db = rec_data(i);
        return v;
    endfunction

    task automatic check(input string tag, input int row, input string f,
                         input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s row %0d %s: got %0h want %0h", tag, row, f, act, exp);
        end
    endtask

    task automatic run_rows(input string tag);
        foreach (tbl[k]) begin
            rst_n = tbl[k].rst; exp_valid = tbl[k].ev; exp_pc = tbl[k].pc;
            exp_sel = tbl[k].sel; exp_sel_dc = tbl[k].sdc; exp_data = tbl[k].data;
            exp_data_dc = tbl[k].ddc; iaddrbus = tbl[k].ia; dselect = tbl[k].ds; dbus = tbl[k].db;
            @(posedge clk);
            #1;
            check(tag, k, "err_pc", 64'(err_pc), 64'(tbl[k].x_pc));
            check(tag, k, "err_sel", 64'(err_sel), 64'(tbl[k].x_sel));
            check(tag, k, "err_data", 64'(err_data), 64'(tbl[k].x_data));
            check(tag, k, "err_idx", 64'(err_idx), 64'(tbl[k].x_idx));
            check(tag, k, "err_count", 64'(err_count), 64'(tbl[k].x_ecnt));
            check(tag, k, "chk_count", 64'(chk_count), 64'(tbl[k].x_ccnt));
            check(tag, k, "pass", 64'(pass), 64'(tbl[k].x_pass));
        end
    endtask

    task automatic do_reset();
        vec_t v = idle_row();
        v.rst = 1'b0;
        v = issue(v, 3);
        tbl.delete();
        tbl.push_back(v);
        run_rows("reset");
    endtask

    // Record k issues in row k and is written back in row k+4; 13 records, 4 drain rows.
    task automatic build_phase1();
        vec_t v;
        tbl.delete();
        for (int k = 0; k < 17; k++) begin
            v = idle_row();
            if (k < 13) v = issue(v, k);
            if (k >= 4) v = wb(v, k - 4);
            v.x_ccnt = (k >= 4) ? 16'(k - 3) : 16'd0;
            v.x_pass = (k >= 4);
            tbl.push_back(v);
        end
    endtask

    initial begin
        vec_t v;

        do_reset();
        build_phase1();
        run_rows("clean");

        do_reset();
        build_phase1();
        tbl[4].db = 64'hAAB;
        tbl[4].x_data = 1'b1;
        for (int k = 4; k < 17; k++) begin
            tbl[k].x_ecnt = 16'd1;
            tbl[k].x_pass = 1'b0;
        end
        run_rows("data_err");

        do_reset();
        build_phase1();
        tbl[1].ia = 64'h8;
        tbl[1].x_pc = 1'b1;
        tbl[10].db = rec_data(6) ^ 64'h1;
        tbl[10].x_data = 1'b1;
        for (int k = 0; k < 17; k++) begin
            tbl[k].x_pass = 1'b0;
            if (k >= 1) tbl[k].x_ecnt = 16'd1;
            if (k >= 10) begin
                tbl[k].x_ecnt = 16'd2;
                tbl[k].x_idx = 16'd6;
            end
        end
        run_rows("pc_then_data");

        do_reset();
        build_phase1();
        tbl[10].ia = 64'h8;
        tbl[10].x_pc = 1'b1;
        tbl[10].db = rec_data(6) ^ 64'h1;
        tbl[10].x_data = 1'b1;
        for (int k = 10; k < 17; k++) begin
            tbl[k].x_ecnt = 16'd1;
            tbl[k].x_idx = 16'd6;
            tbl[k].x_pass = 1'b0;
        end
        run_rows("pc_and_data");

        do_reset();
        tbl.delete();
        for (int k = 0; k < 9; k++) tbl.push_back(idle_row());
        tbl[0] = issue(tbl[0], 10); tbl[0].sdc = 1'b1;
        tbl[2] = issue(tbl[2], 11); tbl[2].ddc = 1'b1;
        tbl[4] = issue(tbl[4], 12); tbl[4].sdc = 1'b1; tbl[4].ddc = 1'b1;
        tbl[4].db = rec_data(10);
        tbl[6].ds = rec_sel(11);
        for (int k = 4; k < 9; k++) begin
            tbl[k].x_pass = 1'b1;
            tbl[k].x_ccnt = (k >= 8) ? 16'd3 : (k >= 6) ? 16'd2 : 16'd1;
        end
        run_rows("bubbles_dc");

        do_reset();
        tbl.delete();
        for (int k = 0; k < 16; k++) tbl.push_back(idle_row());
        for (int k = 0; k < 3; k++) tbl[k] = issue(tbl[k], k);
        tbl[3] = issue(tbl[3], 3);
        tbl[3].rst = 1'b0;
        tbl[9] = issue(tbl[9], 0);
        tbl[10] = issue(tbl[10], 1);
        tbl[13] = wb(tbl[13], 0);
        tbl[14] = wb(tbl[14], 1);
        tbl[14].db = 64'hBAD;
        tbl[13].x_ccnt = 16'd1; tbl[13].x_pass = 1'b1;
        tbl[14].x_data = 1'b1; tbl[14].x_idx = 16'd1; tbl[14].x_ecnt = 16'd1; tbl[14].x_ccnt = 16'd2;
        tbl[15].x_idx = 16'd1; tbl[15].x_ecnt = 16'd1; tbl[15].x_ccnt = 16'd2;
        run_rows("mid_reset");

        do_reset();
        tbl.delete();
        for (int k = 0; k < 6; k++) tbl.push_back(idle_row());
        v = idle_row();
        v.ev = 1'b1; v.pc = 64'h40; v.ia = 64'h40; v.sel = 32'h0030_0000; v.data = 64'h5;
        tbl[0] = v;
        tbl[4].ds = 32'h0030_0000; tbl[4].db = 64'h5;
        for (int k = 4; k < 6; k++) begin
            tbl[k].x_ccnt = 16'd1;
            tbl[k].x_ecnt = OH ? 16'd1 : 16'd0;
            tbl[k].x_pass = !OH;
        end
        tbl[4].x_sel = OH;
        run_rows("onehot");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/wb_check_pipe.md
# wb_check_pipe

Synthesizable writeback checker for the pipelined ARMS core; the checker is parametrised for width, register count and pipeline depth. Per issued instruction it accepts an expected record: PC, destination one-hot and writeback data. It checks the PC in the issue cycle and the writeback PIPE_DEPTH cycles later. It reports mismatches, a saturating error count and the index of the failing instruction. It sits beside the core in simulation or on an FPGA, replacing hand-coded "k-4" checks with a fixed-latency hardware scoreboard.

## Interface
- DATA_W, 64, width of dbus and expected data
- ADDR_W, 64, width of iaddrbus and expected PC
- NREGS, 32, width of dselect (one-hot register select)
- PIPE_DEPTH, 4, cycles from issue to writeback (legal 1..16)
- ERR_W, 16, width of error/check counters
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-low reset
- exp_valid  in  1  expected record present this cycle (instruction issued)
- exp_pc  in  ADDR_W  expected iaddrbus this cycle
- exp_sel  in  NREGS  expected dselect at writeback
- exp_sel_dc  in  1  skip dselect check for this record
- exp_data  in  DATA_W  expected dbus at writeback
- exp_data_dc  in  1  skip dbus check for this record
- iaddrbus  in  ADDR_W  observed PC
- dselect  in  NREGS  observed writeback select
- dbus  in  DATA_W  observed writeback data
- err_pc, err_sel, err_data  out  1  one-cycle mismatch pulses
- err_idx  out  16  tag of the record that caused the latest data/sel error
- err_count  out  ERR_W  cycles with ≥1 error, saturating
- chk_count  out  ERR_W  records retired from pipeline, saturating
- pass  out  1  high when chk_count≠0 and err_count=0

## Operation
- The issue counter is 16 bits and wraps.
  - Each exp_valid cycle tags the record with the current counter value, then increments it.
- The PC check runs in the issue cycle: when exp_valid=1 and iaddrbus≠exp_pc, err_pc fires.
- Each cycle the shift pipeline of PIPE_DEPTH stages advances.
  - Stage 0 loads {exp_valid, sel, sel_dc, data, data_dc, tag}.
  - When exp_valid=0, stage 0 holds a bubble (valid=0).
- Retire stage (stage PIPE_DEPTH-1), when valid:
  - The dselect check runs when sel_dc=0: err_sel on dselect≠sel.
  - The dbus check runs when data_dc=0: err_data on dbus≠data.
  - chk_count increments.
  - err_idx is loaded with the record's tag if err_sel or err_data fires.
- Bubble at retire: no checks, no counter change.
- err_count increments by exactly 1 per cycle in which any of err_pc, err_sel or err_data is set.
  - The increment is 1 even when several flags fire together.
  - err_count holds at all-ones.
- Status FSM:
  - IDLE: after reset; pass=0. Goes to RUN on the first retire.
  - RUN: pass=1. Goes to FAIL on any error.
  - FAIL: sticky until reset; pass=0.

## Timing
- All outputs are registered. Reset values: err_* = 0, err_idx = 0, err_count = 0, chk_count = 0, pass = 0, issue counter = 0, all stages invalid, FSM = IDLE.
- err_pc is asserted in cycle t+1 for a record issued in cycle t.
- For the same record, dselect/dbus are sampled in cycle t+PIPE_DEPTH, and err_sel/err_data are asserted in cycle t+PIPE_DEPTH+1.
- Inputs are sampled on the rising clk edge.
- Reset held low mid-operation:
  - All in-flight records are discarded with no checks.
  - Outputs return to their reset values on the next edge.
  - Records presented while reset=0 are ignored.
- Back-to-back exp_valid every cycle is supported at full throughput; there is no backpressure.
- Issue-counter wrap from 0xFFFF to 0x0000 is silent.
- Counter saturation does not affect the pulses.

## Configuration
- WBCHK_ONEHOT_EN defined:
  - At every retiring valid record with sel_dc=0, dselect is also checked to be exactly one-hot.
  - A dselect that is not one-hot, including all-zero, raises err_sel even if it equals sel.
  - This catches a malformed exp_sel.
- WBCHK_ONEHOT_EN undefined: only the equality check is performed; no one-hot logic is synthesized.

## Test plan
- PIPE_DEPTH=4: issue 13 records matching the core's phase-1 sequence; the observed buses are driven correctly, for example PC 0x0 with ADDI R20→0xAAA, dselect bit 20 at cycle 4 → no err pulses, chk_count=13, pass=1.
- Corrupt dbus to 0xAAB on record 0's writeback cycle → err_data high exactly at cycle 5, err_idx=0, err_count=1, pass=0 thereafter (FAIL sticky).
- Drive iaddrbus=0x8 where exp_pc=0x4 while record 6 carries a dbus error → err_count increments by 1 in each of the two separate cycles where err_pc and err_data fire; in a variant where both flags land in the same cycle, it increments by 1 only.
- Mix bubbles (exp_valid=0) with records flagged data_dc and sel_dc, where observed buses carry garbage → no errors; chk_count counts only valid records.
- Pull reset low for one cycle with 3 records in flight → no retire checks follow, chk_count=0, FSM IDLE; a new record issued afterwards retires PIPE_DEPTH cycles later.
- With WBCHK_ONEHOT_EN, exp_sel=dselect=0x00300000 → err_sel=1; without the macro → err_sel=0.
